dec_prefix_counter: RTL

//  Loadable down-counter. Its next-state decrement is a parallel-prefix borrow network,
//  the subtractive counterpart of the prefix incrementor.

---
 rtl/dec_prefix_counter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dec_prefix_counter.sv
// Loadable down-counter with a prefix-tree borrow decrementer; Q/busy/done move one edge after load/en/ack, no backpressure.
// Define DEC_PREFIX_CNT_RELOAD_EN to auto-reload the last loaded value at terminal count instead of stopping in DONE.
module dec_prefix_counter #(
    parameter int  LOGWIDTH = 5,
    localparam int W        = 1 << LOGWIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         ack,
    output logic [W-1:0] Q,
    output logic         busy,
    output logic         done,
    output logic         Bout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_q;
    logic         r_busy;
    logic         r_done;
`ifdef DEC_PREFIX_CNT_RELOAD_EN
    logic [W-1:0] r_reload;
`endif

    // w_zp[l][i] = AND of ~Q over bits i down to max(0, i-2^l+1): a zero run that propagates borrow.
    logic [W-1:0] w_zp [0:LOGWIDTH];
    logic [W-1:0] w_bin;
    logic [W-1:0] w_dec;
    logic         w_ld_zero;
    logic         w_q_one;

    always_comb begin
        for (int l = 0; l <= LOGWIDTH; l++) begin
            w_zp[l] = '0;
        end
        w_zp[0] = ~r_q;
        for (int l = 0; l < LOGWIDTH; l++) begin
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << l)) begin
                    w_zp[l+1][i] = w_zp[l][i] & w_zp[l][i - (1 << l)];
                end else begin
                    w_zp[l+1][i] = w_zp[l][i];
                end
            end
        end
    end

    // Bit 0 always takes the borrow; bit i takes it when every lower bit is zero.
    assign w_bin     = {w_zp[LOGWIDTH][W-2:0], 1'b1};
    assign w_dec     = r_q ^ w_bin;
    assign Bout      = w_zp[LOGWIDTH][W-1];

    assign w_ld_zero = (load_val == '0);
    assign w_q_one   = (r_q == {{(W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef DEC_PREFIX_CNT_RELOAD_EN
            r_reload <= '0;
`endif
        end else if (load) begin
            // Load wins in every state, over en in RUN and over ack in DONE.
            r_q      <= load_val;
            r_state  <= w_ld_zero ? S_DONE : S_RUN;
            r_busy   <= ~w_ld_zero;
            r_done   <= w_ld_zero;
`ifdef DEC_PREFIX_CNT_RELOAD_EN
            r_reload <= load_val;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
                S_RUN: begin
                    r_done <= 1'b0;
                    if (en) begin
                        if (w_q_one) begin
`ifdef DEC_PREFIX_CNT_RELOAD_EN
                            r_q    <= r_reload;
                            r_done <= 1'b1;
`else
                            r_q     <= '0;
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_q <= w_dec;
                        end
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_q     <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = r_q;
    assign busy = r_busy;
    assign done = r_done;

endmodule
